// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and keeps one request open to IMEM.
// Delivers instr/PC/PC+4 to ID; bubbles are 32'h0. Perf counters: FETCH_PERF_EN.
// Ports: CLK, RESET (sync, high), ID redirect/freeze in, IMEM req/addr/ack/data,
//        Instr1/Instr_PC/Instr_PC_Plus4 out, Fetch/Bubble counters out.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic        IMEM_Req_OUT,
  output logic [31:0] IMEM_Addr_OUT,
  input  logic        IMEM_Ack_IN,
  input  logic [31:0] IMEM_Data_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic [31:0] Fetch_Count_OUT,
  output logic [31:0] Bubble_Count_OUT
);

  typedef enum logic [1:0] {
    FETCH,
    SQUASH,
    HOLD
  } state_t;

  state_t      state, state_nx;
  logic        req;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] redir_pc, redir_pc_nx;
  logic [31:0] buf_w, buf_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic [31:0] instr, instr_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pc4, pc4_nx;
  logic [31:0] del_word, del_pc;
  logic        deliver, bubble;
  logic        ack, freeze, redir;

  // An ack is only meaningful while a request is actually open.
  assign ack    = IMEM_Ack_IN & req;
  assign freeze = WANT_FREEZE_IN;
  assign redir  = Request_Alt_PC_IN;

  always_comb begin
    state_nx    = state;
    req_addr_nx = req_addr;
    redir_pc_nx = redir_pc;
    buf_nx      = buf_w;
    buf_pc_nx   = buf_pc;
    deliver     = 1'b0;
    bubble      = 1'b0;
    del_word    = IMEM_Data_IN;
    del_pc      = req_addr;
    unique case (state)
      FETCH: begin
        if (ack && freeze) begin
          buf_nx      = IMEM_Data_IN;
          buf_pc_nx   = req_addr;
          req_addr_nx = req_addr + 32'd4;
          state_nx    = HOLD;
        end else if (ack && redir) begin
          bubble      = 1'b1;
          req_addr_nx = Alt_PC_IN;
        end else if (ack) begin
          deliver     = 1'b1;
          req_addr_nx = req_addr + 32'd4;
        end else if (!freeze && redir) begin
          bubble      = 1'b1;
          redir_pc_nx = Alt_PC_IN;
          state_nx    = SQUASH;
        end else if (!freeze) begin
          bubble = 1'b1;
        end
      end
      SQUASH: begin
        // The stale request must complete before the target is issued.
        if (ack) begin
          req_addr_nx = redir_pc;
          state_nx    = FETCH;
        end
        bubble = !freeze;
      end
      HOLD: begin
        if (!freeze && redir) begin
          bubble      = 1'b1;
          req_addr_nx = Alt_PC_IN;
          state_nx    = FETCH;
        end else if (!freeze) begin
          deliver  = 1'b1;
          del_word = buf_w;
          del_pc   = buf_pc;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    instr_nx = instr;
    pc_nx    = pc;
    pc4_nx   = pc4;
    if (deliver) begin
      instr_nx = del_word;
      pc_nx    = del_pc;
      pc4_nx   = del_pc + 32'd4;
    end else if (bubble) begin
      instr_nx = 32'h0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= FETCH;
      req      <= 1'b0;
      req_addr <= RESET_PC;
      redir_pc <= 32'h0;
      buf_w    <= 32'h0;
      buf_pc   <= 32'h0;
      instr    <= 32'h0;
      pc       <= 32'h0;
      pc4      <= 32'h0;
    end else begin
      state    <= state_nx;
      req      <= (state_nx != HOLD);
      req_addr <= req_addr_nx;
      redir_pc <= redir_pc_nx;
      buf_w    <= buf_nx;
      buf_pc   <= buf_pc_nx;
      instr    <= instr_nx;
      pc       <= pc_nx;
      pc4      <= pc4_nx;
    end
  end

  assign IMEM_Req_OUT       = req;
  assign IMEM_Addr_OUT      = req_addr;
  assign Instr1_OUT         = instr;
  assign Instr_PC_OUT       = pc;
  assign Instr_PC_Plus4_OUT = pc4;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (deliver) fetch_cnt <= fetch_cnt + 32'd1;
      if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign Fetch_Count_OUT  = fetch_cnt;
  assign Bubble_Count_OUT = bubble_cnt;
`else
  assign Fetch_Count_OUT  = 32'h0;
  assign Bubble_Count_OUT = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, zero-wait, slow memory, redirects,
// freeze, reset in HOLD and PC wrap, with hand-computed expected values.
module tb_instr_fetch;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Alt_PC_IN;
  logic        Request_Alt_PC_IN;
  logic        WANT_FREEZE_IN;
  logic        IMEM_Req_OUT;
  logic [31:0] IMEM_Addr_OUT;
  logic        IMEM_Ack_IN;
  logic [31:0] IMEM_Data_IN;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic [31:0] Fetch_Count_OUT;
  logic [31:0] Bubble_Count_OUT;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.RESET_PC(32'h00400000)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Alt_PC_IN         (Alt_PC_IN),
    .Request_Alt_PC_IN (Request_Alt_PC_IN),
    .WANT_FREEZE_IN    (WANT_FREEZE_IN),
    .IMEM_Req_OUT      (IMEM_Req_OUT),
    .IMEM_Addr_OUT     (IMEM_Addr_OUT),
    .IMEM_Ack_IN       (IMEM_Ack_IN),
    .IMEM_Data_IN      (IMEM_Data_IN),
    .Instr1_OUT        (Instr1_OUT),
    .Instr_PC_OUT      (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
    .Fetch_Count_OUT   (Fetch_Count_OUT),
    .Bubble_Count_OUT  (Bubble_Count_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    Alt_PC_IN = 32'h0;
    Request_Alt_PC_IN = 1'b0;
    WANT_FREEZE_IN = 1'b0;
    IMEM_Ack_IN = 1'b1;
    IMEM_Data_IN = 32'hDEADBEEF;
    step();
    step();
    checks += 5;
    if (Instr1_OUT !== 32'h0) begin
      errors++; $display("FAIL rst_instr got %h want 0", Instr1_OUT);
    end
    if (Instr_PC_OUT !== 32'h0) begin
      errors++; $display("FAIL rst_pc got %h want 0", Instr_PC_OUT);
    end
    if (Instr_PC_Plus4_OUT !== 32'h0) begin
      errors++; $display("FAIL rst_pc4 got %h want 0", Instr_PC_Plus4_OUT);
    end
    if (IMEM_Req_OUT !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b want 0", IMEM_Req_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h00400000) begin
      errors++; $display("FAIL rst_addr got %h want 00400000", IMEM_Addr_OUT);
    end
    checks += 2;
    if (Fetch_Count_OUT !== 32'h0) begin
      errors++; $display("FAIL rst_fcnt got %0d want 0", Fetch_Count_OUT);
    end
    if (Bubble_Count_OUT !== 32'h0) begin
      errors++; $display("FAIL rst_bcnt got %0d want 0", Bubble_Count_OUT);
    end
    IMEM_Ack_IN = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] words [3];
    logic [31:0] epc;
    words[0] = 32'h20080001;
    words[1] = 32'h20090002;
    words[2] = 32'h200A0003;
    RESET = 1'b0;
    step();
    checks += 3;
    if (IMEM_Req_OUT !== 1'b1) begin
      errors++; $display("FAIL zw_req got %b want 1", IMEM_Req_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h00400000) begin
      errors++; $display("FAIL zw_addr0 got %h want 00400000", IMEM_Addr_OUT);
    end
    if (Instr1_OUT !== 32'h0) begin
      errors++; $display("FAIL zw_bub0 got %h want 0", Instr1_OUT);
    end
    for (int i = 0; i < 3; i++) begin
      epc = 32'h00400000 + 32'(4 * i);
      IMEM_Ack_IN = 1'b1;
      IMEM_Data_IN = words[i];
      step();
      checks += 4;
      if (Instr1_OUT !== words[i]) begin
        errors++; $display("FAIL zw_instr%0d got %h want %h", i, Instr1_OUT, words[i]);
      end
      if (Instr_PC_OUT !== epc) begin
        errors++; $display("FAIL zw_pc%0d got %h want %h", i, Instr_PC_OUT, epc);
      end
      if (Instr_PC_Plus4_OUT !== epc + 32'd4) begin
        errors++; $display("FAIL zw_pc4%0d got %h want %h", i, Instr_PC_Plus4_OUT, epc + 32'd4);
      end
      if (IMEM_Addr_OUT !== epc + 32'd4) begin
        errors++; $display("FAIL zw_addr%0d got %h want %h", i, IMEM_Addr_OUT, epc + 32'd4);
      end
    end
    IMEM_Ack_IN = 1'b0;
  endtask

  task automatic test_slow_mem();
    logic [31:0] d [2];
    logic [31:0] a [2];
    logic [31:0] prev;
    d[0] = 32'h8C020010;
    d[1] = 32'hAC030014;
    a[0] = 32'h0040000C;
    a[1] = 32'h00400010;
    prev = 32'h00400008;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 2; w++) begin
        IMEM_Ack_IN = 1'b0;
        step();
        checks += 3;
        if (Instr1_OUT !== 32'h0) begin
          errors++; $display("FAIL slow_bub%0d%0d got %h want 0", k, w, Instr1_OUT);
        end
        if (Instr_PC_OUT !== prev) begin
          errors++; $display("FAIL slow_pchold%0d%0d got %h want %h", k, w, Instr_PC_OUT, prev);
        end
        if (IMEM_Addr_OUT !== a[k]) begin
          errors++; $display("FAIL slow_addr%0d%0d got %h want %h", k, w, IMEM_Addr_OUT, a[k]);
        end
      end
      IMEM_Ack_IN = 1'b1;
      IMEM_Data_IN = d[k];
      step();
      checks += 2;
      if (Instr1_OUT !== d[k]) begin
        errors++; $display("FAIL slow_instr%0d got %h want %h", k, Instr1_OUT, d[k]);
      end
      if (Instr_PC_OUT !== a[k]) begin
        errors++; $display("FAIL slow_pc%0d got %h want %h", k, Instr_PC_OUT, a[k]);
      end
      prev = a[k];
    end
    IMEM_Ack_IN = 1'b0;
    checks += 2;
    if (Fetch_Count_OUT !== (PERF ? 32'd5 : 32'd0)) begin
      errors++; $display("FAIL slow_fcnt got %0d want %0d", Fetch_Count_OUT, PERF ? 5 : 0);
    end
    if (Bubble_Count_OUT !== (PERF ? 32'd5 : 32'd0)) begin
      errors++; $display("FAIL slow_bcnt got %0d want %0d", Bubble_Count_OUT, PERF ? 5 : 0);
    end
  endtask

  task automatic test_redirect_ack();
    IMEM_Ack_IN = 1'b1;
    IMEM_Data_IN = 32'h11111111;
    Request_Alt_PC_IN = 1'b1;
    Alt_PC_IN = 32'h00400100;
    step();
    checks += 4;
    if (Instr1_OUT !== 32'h0) begin
      errors++; $display("FAIL rda_bub got %h want 0", Instr1_OUT);
    end
    if (Instr_PC_OUT !== 32'h00400010) begin
      errors++; $display("FAIL rda_pchold got %h want 00400010", Instr_PC_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h00400100) begin
      errors++; $display("FAIL rda_addr got %h want 00400100", IMEM_Addr_OUT);
    end
    if (IMEM_Req_OUT !== 1'b1) begin
      errors++; $display("FAIL rda_req got %b want 1", IMEM_Req_OUT);
    end
    Request_Alt_PC_IN = 1'b0;
    IMEM_Data_IN = 32'h22222222;
    step();
    checks += 3;
    if (Instr1_OUT !== 32'h22222222) begin
      errors++; $display("FAIL rda_instr got %h want 22222222", Instr1_OUT);
    end
    if (Instr_PC_OUT !== 32'h00400100) begin
      errors++; $display("FAIL rda_pc got %h want 00400100", Instr_PC_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h00400104) begin
      errors++; $display("FAIL rda_next got %h want 00400104", IMEM_Addr_OUT);
    end
  endtask

  task automatic test_redirect_pending();
    IMEM_Ack_IN = 1'b0;
    Request_Alt_PC_IN = 1'b1;
    Alt_PC_IN = 32'h00400200;
    step();
    // Second redirect while squashing must be ignored.
    Alt_PC_IN = 32'h00400300;
    step();
    checks += 3;
    if (Instr1_OUT !== 32'h0) begin
      errors++; $display("FAIL rdp_bub got %h want 0", Instr1_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h00400104) begin
      errors++; $display("FAIL rdp_addr got %h want 00400104", IMEM_Addr_OUT);
    end
    if (IMEM_Req_OUT !== 1'b1) begin
      errors++; $display("FAIL rdp_req got %b want 1", IMEM_Req_OUT);
    end
    Request_Alt_PC_IN = 1'b0;
    IMEM_Ack_IN = 1'b1;
    IMEM_Data_IN = 32'h33333333;
    step();
    checks += 2;
    if (Instr1_OUT !== 32'h0) begin
      errors++; $display("FAIL rdp_drop got %h want 0", Instr1_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h00400200) begin
      errors++; $display("FAIL rdp_tgt got %h want 00400200", IMEM_Addr_OUT);
    end
    IMEM_Data_IN = 32'h44444444;
    step();
    checks += 4;
    if (Instr1_OUT !== 32'h44444444) begin
      errors++; $display("FAIL rdp_instr got %h want 44444444", Instr1_OUT);
    end
    if (Instr_PC_OUT !== 32'h00400200) begin
      errors++; $display("FAIL rdp_pc got %h want 00400200", Instr_PC_OUT);
    end
    if (Fetch_Count_OUT !== (PERF ? 32'd7 : 32'd0)) begin
      errors++; $display("FAIL rdp_fcnt got %0d want %0d", Fetch_Count_OUT, PERF ? 7 : 0);
    end
    if (Bubble_Count_OUT !== (PERF ? 32'd9 : 32'd0)) begin
      errors++; $display("FAIL rdp_bcnt got %0d want %0d", Bubble_Count_OUT, PERF ? 9 : 0);
    end
  endtask

  task automatic test_freeze();
    WANT_FREEZE_IN = 1'b1;
    IMEM_Ack_IN = 1'b1;
    IMEM_Data_IN = 32'h55555555;
    for (int c = 0; c < 4; c++) begin
      step();
      // A stray ack while holding must not overwrite the buffer.
      IMEM_Ack_IN = (c == 1);
      IMEM_Data_IN = 32'h66666666;
      Request_Alt_PC_IN = (c == 2);
      Alt_PC_IN = 32'h00400500;
      checks += 4;
      if (Instr1_OUT !== 32'h44444444) begin
        errors++; $display("FAIL frz_instr%0d got %h want 44444444", c, Instr1_OUT);
      end
      if (Instr_PC_OUT !== 32'h00400200) begin
        errors++; $display("FAIL frz_pc%0d got %h want 00400200", c, Instr_PC_OUT);
      end
      if (IMEM_Req_OUT !== 1'b0) begin
        errors++; $display("FAIL frz_req%0d got %b want 0", c, IMEM_Req_OUT);
      end
      if (IMEM_Addr_OUT !== 32'h00400208) begin
        errors++; $display("FAIL frz_addr%0d got %h want 00400208", c, IMEM_Addr_OUT);
      end
    end
    WANT_FREEZE_IN = 1'b0;
    IMEM_Ack_IN = 1'b0;
    Request_Alt_PC_IN = 1'b0;
    step();
    checks += 6;
    if (Instr1_OUT !== 32'h55555555) begin
      errors++; $display("FAIL frz_buf got %h want 55555555", Instr1_OUT);
    end
    if (Instr_PC_OUT !== 32'h00400204) begin
      errors++; $display("FAIL frz_bufpc got %h want 00400204", Instr_PC_OUT);
    end
    if (Instr_PC_Plus4_OUT !== 32'h00400208) begin
      errors++; $display("FAIL frz_bufpc4 got %h want 00400208", Instr_PC_Plus4_OUT);
    end
    if (IMEM_Req_OUT !== 1'b1 || IMEM_Addr_OUT !== 32'h00400208) begin
      errors++; $display("FAIL frz_next got %b/%h want 1/00400208", IMEM_Req_OUT, IMEM_Addr_OUT);
    end
    if (Fetch_Count_OUT !== (PERF ? 32'd8 : 32'd0)) begin
      errors++; $display("FAIL frz_fcnt got %0d want %0d", Fetch_Count_OUT, PERF ? 8 : 0);
    end
    if (Bubble_Count_OUT !== (PERF ? 32'd9 : 32'd0)) begin
      errors++; $display("FAIL frz_bcnt got %0d want %0d", Bubble_Count_OUT, PERF ? 9 : 0);
    end
  endtask

  task automatic test_reset_in_hold();
    WANT_FREEZE_IN = 1'b1;
    IMEM_Ack_IN = 1'b1;
    IMEM_Data_IN = 32'h77777777;
    step();
    checks += 1;
    if (IMEM_Req_OUT !== 1'b0) begin
      errors++; $display("FAIL rih_hold got %b want 0", IMEM_Req_OUT);
    end
    RESET = 1'b1;
    WANT_FREEZE_IN = 1'b0;
    step();
    checks += 4;
    if (Instr1_OUT !== 32'h0 || Instr_PC_OUT !== 32'h0) begin
      errors++; $display("FAIL rih_out got %h/%h want 0/0", Instr1_OUT, Instr_PC_OUT);
    end
    if (Instr_PC_Plus4_OUT !== 32'h0) begin
      errors++; $display("FAIL rih_pc4 got %h want 0", Instr_PC_Plus4_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h00400000 || IMEM_Req_OUT !== 1'b0) begin
      errors++; $display("FAIL rih_addr got %h/%b want 00400000/0", IMEM_Addr_OUT, IMEM_Req_OUT);
    end
    if (Bubble_Count_OUT !== 32'h0) begin
      errors++; $display("FAIL rih_bcnt got %0d want 0", Bubble_Count_OUT);
    end
    RESET = 1'b0;
    IMEM_Ack_IN = 1'b0;
    step();
    checks += 2;
    if (Instr1_OUT !== 32'h0) begin
      errors++; $display("FAIL rih_nobuf got %h want 0", Instr1_OUT);
    end
    if (IMEM_Req_OUT !== 1'b1) begin
      errors++; $display("FAIL rih_req got %b want 1", IMEM_Req_OUT);
    end
    IMEM_Ack_IN = 1'b1;
    IMEM_Data_IN = 32'h88888888;
    step();
    checks += 2;
    if (Instr1_OUT !== 32'h88888888) begin
      errors++; $display("FAIL rih_instr got %h want 88888888", Instr1_OUT);
    end
    if (Instr_PC_OUT !== 32'h00400000) begin
      errors++; $display("FAIL rih_pc got %h want 00400000", Instr_PC_OUT);
    end
  endtask

  task automatic test_wrap();
    IMEM_Ack_IN = 1'b1;
    IMEM_Data_IN = 32'h99999999;
    Request_Alt_PC_IN = 1'b1;
    Alt_PC_IN = 32'hFFFFFFFC;
    step();
    Request_Alt_PC_IN = 1'b0;
    IMEM_Data_IN = 32'hAAAAAAAA;
    step();
    checks += 5;
    if (Instr1_OUT !== 32'hAAAAAAAA) begin
      errors++; $display("FAIL wrap_instr got %h want aaaaaaaa", Instr1_OUT);
    end
    if (Instr_PC_OUT !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL wrap_pc got %h want fffffffc", Instr_PC_OUT);
    end
    if (Instr_PC_Plus4_OUT !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4 got %h want 0", Instr_PC_Plus4_OUT);
    end
    if (IMEM_Addr_OUT !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %h want 0", IMEM_Addr_OUT);
    end
    if (Fetch_Count_OUT !== (PERF ? 32'd2 : 32'd0)) begin
      errors++; $display("FAIL wrap_fcnt got %0d want %0d", Fetch_Count_OUT, PERF ? 2 : 0);
    end
    IMEM_Ack_IN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_redirect_ack();
    test_redirect_pending();
    test_freeze();
    test_reset_in_hold();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the five-stage MIPS pipeline. Owns the PC and issues one-outstanding requests to instruction memory. Delivers the instruction, its PC and its PC+4 to ID. Consumes ID's `Alt_PC`/`Request_Alt_PC` redirect and `WANT_FREEZE` stall, inserting bubbles (`32'h0`, sll $0) whenever no valid instruction is available.

## Interface
- `RESET_PC`, default `32'h00400000`: first fetch address after reset.
- `CLK` in 1: sole clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `Alt_PC_IN` in 32: redirect target from ID.
- `Request_Alt_PC_IN` in 1: redirect request from ID.
- `WANT_FREEZE_IN` in 1: ID stall; hold outputs, do not advance.
- `IMEM_Req_OUT` out 1: fetch request valid.
- `IMEM_Addr_OUT` out 32: fetch address (word aligned).
- `IMEM_Ack_IN` in 1: response valid; may assert in the same cycle as the request.
- `IMEM_Data_IN` in 32: instruction word, valid with ack.
- `Instr1_OUT` out 32: instruction to ID; `0` is a bubble.
- `Instr_PC_OUT` out 32: PC of `Instr1_OUT`.
- `Instr_PC_Plus4_OUT` out 32: `Instr_PC_OUT + 4`.
- `Fetch_Count_OUT` out 32: delivered-instruction count (see Configuration).
- `Bubble_Count_OUT` out 32: bubble count (see Configuration).

## Operation
- Registers:
  - `ReqAddr`: drives `IMEM_Addr_OUT`.
  - `RedirPC`.
  - `Buf`/`BufPC`: one-entry buffer.
  - State: FETCH, SQUASH or HOLD.
- Request rules:
  - `IMEM_Req_OUT` = 1 in FETCH and SQUASH, 0 in HOLD.
  - Address stays stable until ack; there is only ever one request outstanding.
- "Deliver X" means:
  - `Instr1_OUT<=X`, `Instr_PC_OUT<=pc`, `Instr_PC_Plus4_OUT<=pc+4`.
- "Bubble" means:
  - `Instr1_OUT<=0`; both PC outputs hold.
- "Hold" means:
  - All three ID outputs keep their values.
- FETCH:
  - ack & freeze: `Buf<=IMEM_Data_IN`, `BufPC<=ReqAddr`, `ReqAddr+=4`, go to HOLD; hold.
  - ack & !freeze & redirect: discard data, bubble, `ReqAddr<=Alt_PC_IN`.
  - ack & !freeze & !redirect: deliver data at `ReqAddr`, `ReqAddr+=4`.
  - !ack & !freeze & redirect: bubble, `RedirPC<=Alt_PC_IN`, go to SQUASH.
  - !ack & !freeze: bubble.
  - !ack & freeze: hold.
- SQUASH:
  - Keep the old request asserted.
  - On ack: discard data, `ReqAddr<=RedirPC`, go to FETCH.
  - Outputs bubble, or hold while frozen.
  - `Request_Alt_PC_IN` is ignored.
- HOLD:
  - freeze: hold.
  - !freeze & redirect: discard `Buf`, bubble, `ReqAddr<=Alt_PC_IN`, go to FETCH.
  - !freeze & !redirect: deliver `Buf` at `BufPC`, go to FETCH.
- Freeze priority:
  - Freeze dominates redirect; a redirect sampled during freeze is ignored.
  - ID re-presents the redirect after unfreezing.
- Delay slot: the instruction already on `Instr1_OUT` when the redirect is sampled. The word fetched after it is always discarded.
- Arithmetic:
  - PC adds are 32-bit, wrapping modulo 2^32.
  - `Alt_PC_IN[1:0]` is used as given and not checked.

## Timing
- Reset cycle, all registered:
  - `Instr1_OUT=0`, `Instr_PC_OUT=0`, `Instr_PC_Plus4_OUT=0`.
  - `IMEM_Req_OUT=0`, `IMEM_Addr_OUT=RESET_PC`.
  - State FETCH, `ReqAddr=RESET_PC`, counters 0.
  - An ack arriving in a reset cycle is ignored.
- Reset mid-operation: any outstanding request or buffered word is abandoned; no squash is carried over.
- First edge after reset deassert: `IMEM_Req_OUT=1`.
- Latency and throughput:
  - With a zero-wait memory (ack in the request cycle), the instruction appears at ID one edge after ack.
  - Sustained rate is 1 instr/cycle.
  - N-cycle memory gives N-1 bubbles per instruction.
- Redirect cost:
  - Ack in the redirect cycle: one bubble, then a `Alt_PC_IN` request on the next cycle.
  - Pending request: bubbles until its ack, then the new request.
- Freeze: outputs are stable for every cycle `WANT_FREEZE_IN`=1, plus the edge at which it is sampled.

## Configuration
- `FETCH_PERF_EN` defined:
  - `Fetch_Count_OUT` increments on each delivery.
  - `Bubble_Count_OUT` increments on each bubble cycle (never during hold).
  - Both are 32-bit, wrapping, and reset to 0.
- Undefined: both ports are tied to constant 0 and no counter registers are built.

## Test plan
- Reset with `RESET_PC=0x00400000`, zero-wait memory returning `0x20080001,0x20090002,0x200A0003` -> three consecutive cycles deliver PCs `0x00400000/04/08`, Plus4 `..04/08/0C`, no bubbles.
- Memory with 3-cycle ack -> each instruction followed by 2 bubble cycles (`Instr1_OUT=0`, PC held); `Bubble_Count_OUT` = 2x `Fetch_Count_OUT` with `FETCH_PERF_EN`.
- Redirect to `0x00400100` in the cycle the ack for `0x00400008` arrives -> one bubble, then `IMEM_Addr_OUT=0x00400100`; `0x00400008` never delivered.
- Redirect while the `0x0040000C` request is pending for 2 more cycles -> SQUASH; `Addr` stays `0x0040000C` until ack; next request `Alt_PC_IN`; no delivery of `0x0040000C`.
- Freeze for 4 cycles with ack arriving in the first -> outputs constant, `IMEM_Req_OUT=0` for the remaining frozen cycles; after release `Buf` delivered with correct PC, next request at PC+4.
- Assert `RESET` while in HOLD -> next cycle all ID outputs 0, `IMEM_Addr_OUT=RESET_PC`, buffered word never delivered.
